// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/subtract split into STAGES registered
// ripple-carry slices, valid/ready streaming with backpressure.
// Optional feature macro: ADDER_OVERFLOW_EN adds o_overflow (signed overflow of
// the op currently presented on o_result).
module pipelined_carry_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
`ifdef ADDER_OVERFLOW_EN
    output logic             o_overflow,
`endif
    output logic [WIDTH:0]   o_result
);

    localparam int SLICE = WIDTH / STAGES;

    // Stage k registers hold the operands, the sum bits completed so far and
    // the carry out of slice k. Lower operand bits in later stages go unused.
    logic [STAGES-1:0]            r_vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0] r_a;
    logic [STAGES-1:0][WIDTH-1:0] r_b;
    logic [STAGES-1:0][WIDTH-1:0] r_sum;
    logic [STAGES-1:0]            r_c;

    logic [STAGES-1:0][WIDTH-1:0] w_a_in;
    logic [STAGES-1:0][WIDTH-1:0] w_b_in;
    logic [STAGES-1:0][WIDTH-1:0] w_sum_in;
    logic [STAGES-1:0][WIDTH-1:0] w_sum_out;
    logic [STAGES-1:0]            w_c_in;
    logic [STAGES-1:0]            w_c_out;
    logic                         w_adv;
`ifdef ADDER_OVERFLOW_EN
    logic                         w_c_msb;
    logic                         r_ovf;
`endif

    // Pipeline advances unless the output holds a result nobody is taking.
    always_comb begin
        w_adv = !r_vld_pipe[STAGES-1] || i_ready;
    end

    assign o_ready  = w_adv;
    assign o_valid  = r_vld_pipe[STAGES-1];
    assign o_result = {r_c[STAGES-1], r_sum[STAGES-1]};
`ifdef ADDER_OVERFLOW_EN
    assign o_overflow = r_ovf;
`endif

    // Slice inputs: stage 0 from the ports (B inverted and carry flipped for
    // subtract), later stages from the previous stage's registers.
    always_comb begin
        w_a_in   = '0;
        w_b_in   = '0;
        w_sum_in = '0;
        w_c_in   = '0;
        w_a_in[0] = i_add_term1;
        w_b_in[0] = i_sub ? ~i_add_term2 : i_add_term2;
        w_c_in[0] = i_sub ^ i_carry;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_sum_in[k] = r_sum[k-1];
            w_c_in[k]   = r_c[k-1];
        end
    end

    // Ripple-carry add of each stage's own SLICE bits.
    always_comb begin
        logic c;
        w_sum_out = w_sum_in;
        w_c_out   = '0;
`ifdef ADDER_OVERFLOW_EN
        w_c_msb   = 1'b0;
`endif
        for (int k = 0; k < STAGES; k++) begin
            c = w_c_in[k];
            for (int j = 0; j < SLICE; j++) begin
                w_sum_out[k][k*SLICE+j] = w_a_in[k][k*SLICE+j] ^ w_b_in[k][k*SLICE+j] ^ c;
`ifdef ADDER_OVERFLOW_EN
                if (k*SLICE+j == WIDTH-1) w_c_msb = c;
`endif
                c = (w_a_in[k][k*SLICE+j] & w_b_in[k][k*SLICE+j]) |
                    (c & (w_a_in[k][k*SLICE+j] ^ w_b_in[k][k*SLICE+j]));
            end
            w_c_out[k] = c;
        end
    end

    // Stage registers: shift together on advance, hold everything on stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_c        <= '0;
        end else if (w_adv) begin
            r_vld_pipe[0] <= i_valid;
            if (i_valid) begin
                r_a[0]   <= w_a_in[0];
                r_b[0]   <= w_b_in[0];
                r_sum[0] <= w_sum_out[0];
                r_c[0]   <= w_c_out[0];
            end
            for (int k = 1; k < STAGES; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_a[k]        <= w_a_in[k];
                r_b[k]        <= w_b_in[k];
                r_sum[k]      <= w_sum_out[k];
                r_c[k]        <= w_c_out[k];
            end
        end
    end

`ifdef ADDER_OVERFLOW_EN
    // Signed overflow moves with the final stage so it stays paired with o_result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv && (STAGES > 1 || i_valid)) begin
            r_ovf <= w_c_msb ^ w_c_out[STAGES-1];
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=8, STAGES=2):
// directed corner ops, stall, mid-flight reset and randomized streaming
// against an arithmetic reference model.
module tb_pipelined_carry_adder;
    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         o_valid;
    logic         i_ready;
    logic [W:0]   o_result;
`ifdef ADDER_OVERFLOW_EN
    logic         o_overflow;
`endif

    pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_add_term1(a), .i_add_term2(b), .i_carry(cin), .i_sub(sub),
        .o_valid(o_valid), .i_ready(i_ready),
`ifdef ADDER_OVERFLOW_EN
        .o_overflow(o_overflow),
`endif
        .o_result(o_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W:0] res;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        longint ux, uy, t, sx, sy, r;
        exp_t e;
        ux = longint'(x);
        uy = longint'(y);
        if (!s) begin
            t = ux + uy + longint'(c);
            e.res = t[W:0];
        end else begin
            t = ux - uy - longint'(c);
            e.res[W-1:0] = t[W-1:0];
            e.res[W] = (ux >= uy + longint'(c));
        end
        sx = (ux >= (longint'(1) << (W-1))) ? ux - (longint'(1) << W) : ux;
        sy = (uy >= (longint'(1) << (W-1))) ? uy - (longint'(1) << W) : uy;
        r  = s ? sx - sy - longint'(c) : sx + sy + longint'(c);
        e.ovf = (r > (longint'(1) << (W-1)) - 1) || (r < -(longint'(1) << (W-1)));
        return e;
    endfunction

    // Monitor: handshake rule, stall stability and in-order scoreboard.
    logic [W:0] held;
    logic       held_v = 1'b0;
    exp_t       e_pop;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            chk("o_ready_rule", o_ready, !o_valid || i_ready);
            if (held_v) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_hold", o_result, held);
            end
            held_v = o_valid && !i_ready;
            held   = o_result;
            if (o_valid && i_ready) begin
                chk("q_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e_pop = q.pop_front();
                    chk("result", o_result, e_pop.res);
`ifdef ADDER_OVERFLOW_EN
                    chk("overflow", o_overflow, e_pop.ovf);
`endif
                end
            end
            if (i_valid && o_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    // Present one op (called at posedge+1); returns at posedge+1 after accept.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s);
        logic acc;
        int   n;
        a = x; b = y; cin = c; sub = s; i_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("send_timeout", n, 0);
        i_valid = 1'b0;
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic s, input logic [W:0] exp);
        int n;
        send(x, y, c, s);
        n = 1;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, S);
        chk("directed_res", o_result, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_ready", o_ready, 1);

        directed(8'h7F, 8'h01, 1'b0, 1'b0, 9'h080);
        directed(8'hFF, 8'h01, 1'b1, 1'b0, 9'h101);
        directed(8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE);
        directed(8'h07, 8'h05, 1'b0, 1'b1, 9'h102);
        directed(8'h00, 8'h00, 1'b1, 1'b1, 9'h0FF);

        // Back-to-back stream with a 3-cycle downstream stall in the middle.
        fork
            begin
                send(8'h11, 8'h22, 1'b0, 1'b0);
                send(8'h80, 8'h80, 1'b0, 1'b0);
                send(8'h30, 8'h31, 1'b1, 1'b1);
                send(8'hA5, 8'h5A, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_oready", o_ready, 0);
                    @(posedge clk); #1;
                end
                i_ready = 1'b1;
            end
        join
        repeat (S + 2) @(posedge clk);
        #1;
        chk("stream_drain", q.size(), 0);

        // Reset with two ops in flight: nothing stale may emerge.
        send(8'h12, 8'h34, 1'b0, 1'b0);
        send(8'h56, 8'h78, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_result", o_result, 0);
        chk("midrst_ready", o_ready, 1);
        repeat (S + 3) begin
            @(negedge clk);
            chk("midrst_no_stale", o_valid, 0);
        end
        @(posedge clk); #1;

        // Randomized streaming with random backpressure and bubbles.
        for (int i = 0; i < 400; i++) begin
            i_valid = ($urandom % 3) != 0;
            i_ready = ($urandom % 4) != 0;
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() > 0; n++) begin
            @(posedge clk); #1;
        end
        chk("final_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
